// File: rtl/vscale_hpm_counter_bank.sv
// ---------------------------------------------------------------------------
// vscale_hpm_counter_bank
//
// Purpose:
//   Bank of N_CNT hardware performance-monitor counters (mhpmcounter3 and up).
//   Each counter counts one event picked from the events vector by its
//   mhpmevent selector. Counters can be stopped through mcountinhibit. A
//   counter that wraps from all-ones sets its overflow-pending bit, and the
//   enabled pending bits are ORed into a registered interrupt line.
//   The block sits beside the CSR file on the shared CSR bus. The CSR file
//   ORs rdata/defined into its own read path for the addresses claimed here.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   events         per-cycle event strobes
//   addr           CSR address
//   cmd            CSR command (cmd[2] = access, cmd[1]|cmd[0] = write;
//                  01 write, 10 set, 11 clear)
//   wdata          CSR write operand
//   prv            current privilege level
//   rdata          combinational read data, 0 when addr is not claimed
//   defined        addr is claimed by this block
//   illegal_access privilege or read-only violation on a claimed address
//   ovf_irq        registered OR of enabled overflow-pending bits
//
// Configuration:
//   VSCALE_HPM_SHADOW_EN  when defined, user read-only shadows hpmcounter
//                         (12'hC03+i) and hpmcounterh (12'hC83+i) are claimed.
//                         They read like the M-mode copies, and any write to
//                         them is illegal.
// ---------------------------------------------------------------------------
module vscale_hpm_counter_bank #(
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 64,
  parameter int N_EVENTS  = 8,
  parameter int EVSEL_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_EVENTS-1:0] events,
  input  logic [11:0]         addr,
  input  logic [2:0]          cmd,
  input  logic [31:0]         wdata,
  input  logic [1:0]          prv,
  output logic [31:0]         rdata,
  output logic                defined,
  output logic                illegal_access,
  output logic                ovf_irq
);

  logic [CNT_WIDTH-1:0] cnt   [N_CNT];
  logic [EVSEL_W-1:0]   evsel [N_CNT];
  logic [N_CNT-1:0]     inhibit;
  logic [N_CNT-1:0]     ovf;
  logic [N_CNT-1:0]     ovf_ie;

  logic             is_write;
  logic             wr_en;
  logic [31:0]      wr_val;
  logic [N_CNT-1:0] wr_lo;
  logic [N_CNT-1:0] wr_hi;
  logic [N_CNT-1:0] wr_ev;
  logic [N_CNT-1:0] cnt_inc;
  logic [N_CNT-1:0] ovf_wrap;
  logic [N_CNT-1:0] ovf_nxt;
  logic [N_CNT-1:0] ovf_ie_nxt;

  // Read mux and address claim. The user shadows alias the M-mode counters
  // only when the shadow feature is built in.
  always_comb begin
    rdata   = '0;
    defined = 1'b0;
    for (int i = 0; i < N_CNT; i++) begin
      if (addr == 12'(12'hB03 + i)) begin
        defined = 1'b1;
        rdata   = cnt[i][31:0];
      end
      if (addr == 12'(12'hB83 + i)) begin
        defined = 1'b1;
        rdata   = 32'(cnt[i] >> 32);
      end
`ifdef VSCALE_HPM_SHADOW_EN
      if (addr == 12'(12'hC03 + i)) begin
        defined = 1'b1;
        rdata   = cnt[i][31:0];
      end
      if (addr == 12'(12'hC83 + i)) begin
        defined = 1'b1;
        rdata   = 32'(cnt[i] >> 32);
      end
`endif
      if (addr == 12'(12'h323 + i)) begin
        defined = 1'b1;
        rdata   = 32'(evsel[i]);
      end
    end
    case (addr)
      12'h320: begin
        defined = 1'b1;
        rdata   = 32'(inhibit) << 3;
      end
      12'h7C0: begin
        defined = 1'b1;
        rdata   = 32'(ovf);
      end
      12'h7C1: begin
        defined = 1'b1;
        rdata   = 32'(ovf_ie);
      end
      default: ;
    endcase
  end

  // Access checks. addr[9:8] is the lowest privilege allowed to touch the
  // CSR, and addr[11:10] == 2'b11 marks a read-only CSR.
  always_comb begin
    is_write       = cmd[1] | cmd[0];
    illegal_access = defined & cmd[2] &
                     ((addr[9:8] > prv) | (is_write & (addr[11:10] == 2'b11)));
    wr_en          = cmd[2] & is_write & defined & ~illegal_access;
  end

  // Value to commit for write/set/clear. Set and clear modify the current
  // read value, so unimplemented bits stay zero.
  always_comb begin
    case (cmd[1:0])
      2'b01:   wr_val = wdata;
      2'b10:   wr_val = rdata | wdata;
      2'b11:   wr_val = rdata & ~wdata;
      default: wr_val = rdata;
    endcase
  end

  // Per-counter write strobes and the event match. Event selector value k
  // picks events[k-1]. Selector 0 and values above N_EVENTS never match.
  always_comb begin
    wr_lo   = '0;
    wr_hi   = '0;
    wr_ev   = '0;
    cnt_inc = '0;
    for (int i = 0; i < N_CNT; i++) begin
      wr_lo[i] = wr_en & (addr == 12'(12'hB03 + i));
      wr_hi[i] = wr_en & (addr == 12'(12'hB83 + i));
      wr_ev[i] = wr_en & (addr == 12'(12'h323 + i));
      for (int e = 0; e < N_EVENTS; e++) begin
        if (!inhibit[i] && events[e] && (evsel[i] == EVSEL_W'(e + 1)))
          cnt_inc[i] = 1'b1;
      end
    end
  end

  // Overflow bookkeeping. A CSR write to a counter cancels that cycle's
  // increment, so that counter cannot wrap. A fresh wrap is ORed in after
  // the CSR update, so it wins over a same-cycle clear of its pending bit.
  always_comb begin
    ovf_wrap   = '0;
    ovf_nxt    = ovf;
    ovf_ie_nxt = ovf_ie;
    for (int i = 0; i < N_CNT; i++)
      ovf_wrap[i] = cnt_inc[i] & ~wr_lo[i] & ~wr_hi[i] & (cnt[i] == '1);
    if (wr_en && (addr == 12'h7C0))
      ovf_nxt = wr_val[N_CNT-1:0];
    if (wr_en && (addr == 12'h7C1))
      ovf_ie_nxt = wr_val[N_CNT-1:0];
    ovf_nxt = ovf_nxt | ovf_wrap;
  end

  // State update. A CSR write to either half of a counter takes priority
  // over that counter's increment. The interrupt is registered from the
  // next-state pending and enable bits, so it tracks them with no extra lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt[i]   <= '0;
        evsel[i] <= '0;
      end
      inhibit <= '0;
      ovf     <= '0;
      ovf_ie  <= '0;
      ovf_irq <= 1'b0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (wr_lo[i])
          cnt[i][31:0] <= wr_val;
        else if (wr_hi[i])
          cnt[i][CNT_WIDTH-1:32] <= wr_val[CNT_WIDTH-33:0];
        else if (cnt_inc[i])
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        if (wr_ev[i])
          evsel[i] <= wr_val[EVSEL_W-1:0];
      end
      if (wr_en && (addr == 12'h320))
        inhibit <= wr_val[N_CNT+2:3];
      ovf     <= ovf_nxt;
      ovf_ie  <= ovf_ie_nxt;
      ovf_irq <= |(ovf_nxt & ovf_ie_nxt);
    end
  end

endmodule

// File: tb/tb_vscale_hpm_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_vscale_hpm_counter_bank
//
// Scoreboard bench for the HPM counter bank. The stimulus process drives
// one CSR/event vector per cycle. For each vector it pushes the expected
// combinational response, taken from a behavioural model of the counter
// bank, into a queue. A monitor process pops each expectation on the
// falling edge and compares it against the DUT.
// Compile with VSCALE_HPM_SHADOW_EN defined to expect the user shadows.
// ---------------------------------------------------------------------------
module tb_vscale_hpm_counter_bank;

  localparam int N_CNT     = 4;
  localparam int CNT_WIDTH = 64;
  localparam int N_EVENTS  = 8;
  localparam int EVSEL_W   = 4;
  localparam logic [63:0] CNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - CNT_WIDTH);

  localparam logic [2:0] CSR_IDLE  = 3'd0;
  localparam logic [2:0] CSR_READ  = 3'd4;
  localparam logic [2:0] CSR_WRITE = 3'd5;
  localparam logic [2:0] CSR_SET   = 3'd6;
  localparam logic [2:0] CSR_CLEAR = 3'd7;

  logic                clk;
  logic                reset;
  logic [N_EVENTS-1:0] events;
  logic [11:0]         addr;
  logic [2:0]          cmd;
  logic [31:0]         wdata;
  logic [1:0]          prv;
  logic [31:0]         rdata;
  logic                defined;
  logic                illegal_access;
  logic                ovf_irq;

  vscale_hpm_counter_bank #(
    .N_CNT    (N_CNT),
    .CNT_WIDTH(CNT_WIDTH),
    .N_EVENTS (N_EVENTS),
    .EVSEL_W  (EVSEL_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .events        (events),
    .addr          (addr),
    .cmd           (cmd),
    .wdata         (wdata),
    .prv           (prv),
    .rdata         (rdata),
    .defined       (defined),
    .illegal_access(illegal_access),
    .ovf_irq       (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        defined;
    logic        illegal;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural model state: plain values per counter.
  logic [63:0] m_cnt   [N_CNT];
  int          m_evsel [N_CNT];
  bit          m_inh   [N_CNT];
  bit          m_ovf   [N_CNT];
  bit          m_ie    [N_CNT];
  bit          m_irq;

  function automatic void model_reset();
    for (int i = 0; i < N_CNT; i++) begin
      m_cnt[i]   = 64'd0;
      m_evsel[i] = 0;
      m_inh[i]   = 1'b0;
      m_ovf[i]   = 1'b0;
      m_ie[i]    = 1'b0;
    end
    m_irq = 1'b0;
  endfunction

  function automatic void model_read(input logic [11:0] a, output bit def, output logic [31:0] rd);
    def = 1'b0;
    rd  = 32'd0;
    for (int i = 0; i < N_CNT; i++) begin
      if (a == 12'(12'hB03 + i)) begin def = 1'b1; rd = m_cnt[i][31:0]; end
      if (a == 12'(12'hB83 + i)) begin def = 1'b1; rd = 32'(m_cnt[i] >> 32); end
`ifdef VSCALE_HPM_SHADOW_EN
      if (a == 12'(12'hC03 + i)) begin def = 1'b1; rd = m_cnt[i][31:0]; end
      if (a == 12'(12'hC83 + i)) begin def = 1'b1; rd = 32'(m_cnt[i] >> 32); end
`endif
      if (a == 12'(12'h323 + i)) begin def = 1'b1; rd = 32'(m_evsel[i]); end
    end
    if (a == 12'h320) begin
      def = 1'b1;
      for (int i = 0; i < N_CNT; i++) if (m_inh[i]) rd = rd | (32'd1 << (3 + i));
    end
    if (a == 12'h7C0) begin
      def = 1'b1;
      for (int i = 0; i < N_CNT; i++) if (m_ovf[i]) rd = rd | (32'd1 << i);
    end
    if (a == 12'h7C1) begin
      def = 1'b1;
      for (int i = 0; i < N_CNT; i++) if (m_ie[i]) rd = rd | (32'd1 << i);
    end
  endfunction

  function automatic bit model_illegal(input logic [11:0] a, input logic [2:0] c,
                                       input logic [1:0] p, input bit def);
    bit wr = c[1] | c[0];
    return def && c[2] && ((a[9:8] > p) || (wr && a[11:10] == 2'b11));
  endfunction

  // One clock edge of the model: every rule is evaluated from the
  // pre-edge state and then all results are committed together.
  function automatic void model_step(input logic [11:0] a, input logic [2:0] c, input logic [31:0] w,
                                     input logic [1:0] p, input logic [N_EVENTS-1:0] ev);
    bit          def, ill, do_wr, any;
    logic [31:0] rd, wv;
    logic [63:0] n_cnt [N_CNT];
    bit          wrapped [N_CNT];
    model_read(a, def, rd);
    ill   = model_illegal(a, c, p, def);
    do_wr = c[2] && (c[1] | c[0]) && def && !ill;
    case (c[1:0])
      2'b01:   wv = w;
      2'b10:   wv = rd | w;
      2'b11:   wv = rd & ~w;
      default: wv = rd;
    endcase
    for (int i = 0; i < N_CNT; i++) begin
      wrapped[i] = 1'b0;
      n_cnt[i]   = m_cnt[i];
      if (do_wr && a == 12'(12'hB03 + i))
        n_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(wv);
      else if (do_wr && a == 12'(12'hB83 + i))
        n_cnt[i] = ((64'(wv) << 32) | (m_cnt[i] & 64'hFFFF_FFFF)) & CNT_MAX;
      else if (!m_inh[i] && m_evsel[i] >= 1 && m_evsel[i] <= N_EVENTS && ev[m_evsel[i] - 1]) begin
        if (m_cnt[i] == CNT_MAX) begin
          n_cnt[i]   = 64'd0;
          wrapped[i] = 1'b1;
        end else begin
          n_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
    end
    for (int i = 0; i < N_CNT; i++) begin
      m_cnt[i] = n_cnt[i];
      if (do_wr && a == 12'(12'h323 + i)) m_evsel[i] = int'(wv) & ((1 << EVSEL_W) - 1);
      if (do_wr && a == 12'h320) m_inh[i] = wv[3 + i];
      if (do_wr && a == 12'h7C0) m_ovf[i] = wv[i];
      if (do_wr && a == 12'h7C1) m_ie[i] = wv[i];
      if (wrapped[i]) m_ovf[i] = 1'b1;
    end
    any = 1'b0;
    for (int i = 0; i < N_CNT; i++) if (m_ovf[i] && m_ie[i]) any = 1'b1;
    m_irq = any;
  endfunction

  function automatic exp_t expect_now(input string name, input logic [11:0] a,
                                      input logic [2:0] c, input logic [1:0] p);
    exp_t e;
    bit   def;
    logic [31:0] rd;
    model_read(a, def, rd);
    e.rdata   = rd;
    e.defined = def;
    e.illegal = model_illegal(a, c, p, def);
    e.irq     = m_irq;
    e.name    = name;
    return e;
  endfunction

  // Drive one vector just after a rising edge, queue the expected response
  // and advance the model to the following edge.
  task automatic applyStimulus(input string name, input logic [11:0] a, input logic [2:0] c,
                               input logic [31:0] w, input logic [1:0] p,
                               input logic [N_EVENTS-1:0] ev);
    addr   = a;
    cmd    = c;
    wdata  = w;
    prv    = p;
    events = ev;
    sb.push_back(expect_now(name, a, c, p));
    model_step(a, c, w, p, ev);
    @(posedge clk);
    #1;
  endtask

  // Raise reset in the middle of a cycle and expect the cleared state
  // before any clock edge has occurred.
  task automatic asyncReset(input string name, input logic [11:0] a);
    addr   = a;
    cmd    = CSR_READ;
    wdata  = 32'd0;
    prv    = 2'd3;
    events = '1;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    sb.push_back(expect_now(name, a, CSR_READ, 2'd3));
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_step(a, CSR_READ, 32'd0, 2'd3, '1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (rdata !== e.rdata || defined !== e.defined || illegal_access !== e.illegal || ovf_irq !== e.irq) begin
      miscompares++;
      $display("[TB] FAIL %s: got rdata=%h defined=%b illegal=%b irq=%b, want rdata=%h defined=%b illegal=%b irq=%b",
               e.name, rdata, defined, illegal_access, ovf_irq, e.rdata, e.defined, e.illegal, e.irq);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is a compare.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    logic [2:0]  cmds [5];
    logic [11:0] a;
    logic [31:0] w;
    logic [1:0]  p;
    int          k;
    int          guard;
    cmds[0] = CSR_IDLE; cmds[1] = CSR_READ; cmds[2] = CSR_WRITE; cmds[3] = CSR_SET; cmds[4] = CSR_CLEAR;

    reset  = 1'b1;
    addr   = 12'd0;
    cmd    = CSR_IDLE;
    wdata  = 32'd0;
    prv    = 2'd3;
    events = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("reset_cnt3", 12'hB03, CSR_READ, 0, 3, 0);
    applyStimulus("reset_inhibit", 12'h320, CSR_READ, 0, 3, 0);
    applyStimulus("reset_ovf", 12'h7C0, CSR_READ, 0, 3, 0);

    // Ten event cycles on event 1.
    applyStimulus("t1_evsel", 12'h323, CSR_WRITE, 1, 3, 0);
    repeat (10) applyStimulus("t1_count", 12'hB03, CSR_READ, 0, 3, 8'h01);
    applyStimulus("t1_lo", 12'hB03, CSR_READ, 0, 3, 0);
    applyStimulus("t1_hi", 12'hB83, CSR_READ, 0, 3, 0);
    applyStimulus("t1_other", 12'hB04, CSR_READ, 0, 3, 0);

    // Wrap to zero, pending interrupt, then clear.
    applyStimulus("t2_wr_hi", 12'hB83, CSR_WRITE, 32'hFFFF_FFFF, 3, 0);
    applyStimulus("t2_wr_lo", 12'hB03, CSR_WRITE, 32'hFFFF_FFFE, 3, 0);
    applyStimulus("t2_wr_ie", 12'h7C1, CSR_WRITE, 1, 3, 0);
    repeat (2) applyStimulus("t2_count", 12'h7C0, CSR_READ, 0, 3, 8'h01);
    applyStimulus("t2_lo", 12'hB03, CSR_READ, 0, 3, 0);
    applyStimulus("t2_hi", 12'hB83, CSR_READ, 0, 3, 0);
    applyStimulus("t2_clear", 12'h7C0, CSR_CLEAR, 1, 3, 0);
    applyStimulus("t2_after_clear", 12'h7C0, CSR_READ, 0, 3, 0);

    // Write wins over increment; inhibit freezes the counter.
    applyStimulus("t3_wr_vs_inc", 12'hB03, CSR_WRITE, 5, 3, 8'h01);
    applyStimulus("t3_read5", 12'hB03, CSR_READ, 0, 3, 0);
    applyStimulus("t3_inhibit", 12'h320, CSR_WRITE, 32'h8, 3, 0);
    repeat (20) applyStimulus("t3_hold", 12'hB03, CSR_READ, 0, 3, 8'hFF);
    applyStimulus("t3_uninhibit", 12'h320, CSR_WRITE, 0, 3, 0);

    // Privilege and read-only checks.
    applyStimulus("t4_u_read_m", 12'hB03, CSR_READ, 0, 0, 8'h01);
    applyStimulus("t4_u_write_shadow", 12'hC03, CSR_WRITE, 7, 0, 0);
    applyStimulus("t4_u_read_shadow", 12'hC03, CSR_READ, 0, 0, 0);
    applyStimulus("t4_u_read_shadow_hi", 12'hC83, CSR_READ, 0, 0, 0);

    // Out-of-range and zero selectors never count; async reset mid-count.
    applyStimulus("t5_evsel_big", 12'h323, CSR_WRITE, N_EVENTS + 1, 3, 0);
    repeat (5) applyStimulus("t5_nocount_big", 12'hB03, CSR_READ, 0, 3, 8'hFF);
    applyStimulus("t5_evsel_zero", 12'h323, CSR_WRITE, 0, 3, 0);
    repeat (5) applyStimulus("t5_nocount_zero", 12'hB03, CSR_READ, 0, 3, 8'hFF);
    applyStimulus("t5_evsel_one", 12'h323, CSR_WRITE, 1, 3, 0);
    repeat (3) applyStimulus("t5_count", 12'hB03, CSR_READ, 0, 3, 8'hFF);
    asyncReset("t5_async_reset", 12'hB03);
    applyStimulus("t5_evsel_after", 12'h323, CSR_READ, 0, 3, 0);

    // Wrap in the same cycle as a clear of the pending bit.
    applyStimulus("t6_evsel", 12'h323, CSR_WRITE, 1, 3, 0);
    applyStimulus("t6_set_ovf", 12'h7C0, CSR_WRITE, 1, 3, 0);
    applyStimulus("t6_set_ie", 12'h7C1, CSR_WRITE, 1, 3, 0);
    applyStimulus("t6_wr_hi", 12'hB83, CSR_WRITE, 32'hFFFF_FFFF, 3, 0);
    applyStimulus("t6_wr_lo", 12'hB03, CSR_WRITE, 32'hFFFF_FFFF, 3, 0);
    applyStimulus("t6_wrap_clear", 12'h7C0, CSR_CLEAR, 1, 3, 8'h01);
    applyStimulus("t6_ovf_kept", 12'h7C0, CSR_READ, 0, 3, 0);

    // Randomized traffic across the claimed map and some random addresses.
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, N_CNT - 1);
      case ($urandom_range(0, 9))
        0, 1:    a = 12'(12'hB03 + k);
        2:       a = 12'(12'hB83 + k);
        3:       a = 12'(12'h323 + k);
        4:       a = 12'h320;
        5:       a = 12'h7C0;
        6:       a = 12'h7C1;
        7:       a = 12'(12'hC03 + k);
        8:       a = 12'(12'hC83 + k);
        default: a = 12'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       w = $urandom;
        1:       w = 32'hFFFF_FFFF;
        2:       w = 32'hFFFF_FFFD;
        default: w = $urandom_range(0, 15);
      endcase
      p = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd3;
      applyStimulus("random", a, cmds[$urandom_range(0, 4)], w, p, N_EVENTS'($urandom));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
